// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared types and constants for the restoring-division
// sequencer.
//   div_state_e    - controller states (IDLE, LOAD, SHIFT0, ITER, FIX, DONE)
//   ALU_SUBU/NOP   - ALU funct codes, the same encoding the multiplier controller uses
//   alu_for_state  - funct code driven while a given state is current
package div_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT0 = 3'd2,
    ITER   = 3'd3,
    FIX    = 3'd4,
    DONE   = 3'd5
  } div_state_e;

  localparam logic [5:0] ALU_SUBU = 6'b100011;
  localparam logic [5:0] ALU_NOP  = 6'b000000;

  // Only the iteration state uses the subtractor; everything else idles the ALU.
  function automatic logic [5:0] alu_for_state(input div_state_e st);
    logic [5:0] funct;
    case (st)
      ITER:    funct = ALU_SUBU;
      default: funct = ALU_NOP;
    endcase
    return funct;
  endfunction

endpackage

// File: rtl/div_iter_counter.sv
// div_iter_counter: counts quotient iterations for div_control.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset (count -> 0)
//   clr   - synchronous clear (count -> 0), has priority over inc
//   inc   - count up by one
//   term  - high while the count equals WIDTH-1 (last iteration in progress)
module div_iter_counter
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next-count selection: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/div_control.sv
// div_control: sequencing FSM for a multi-cycle restoring divider.
// One quotient bit per ITER cycle: the datapath subtracts the divisor from
// rem_hi, writes the difference back when it is non-negative, then shifts the
// remainder register left inserting the quotient bit. FIX shifts rem_hi right
// once to undo the extra shift. Divide-by-zero skips the datapath entirely.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   run          - start request, sampled in IDLE (held high keeps DONE)
//   msb          - sign of (rem_hi - divisor), used only in ITER
//   div_zero     - divisor == 0 flag, used only in IDLE
//   load_ctrl    - load dividend / latch divisor (LOAD)
//   alu_ctrl     - ALU funct: SUBU in ITER, NOP otherwise
//   w_ctrl       - write ALU difference into rem_hi (ITER, msb == 0)
//   sll_ctrl     - shift remainder left inserting q_bit (SHIFT0, ITER)
//   q_bit        - quotient bit inserted on shift
//   srh_ctrl     - shift rem_hi right (FIX)
//   ready        - result valid (DONE)
//   dz           - divide-by-zero flag, valid with ready
module div_control
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       msb,
  input  logic       div_zero,
  output logic       load_ctrl,
  output logic [5:0] alu_ctrl,
  output logic       w_ctrl,
  output logic       sll_ctrl,
  output logic       q_bit,
  output logic       srh_ctrl,
  output logic       ready,
  output logic       dz
);

  div_state_e state_q, state_d;
  logic       dz_q, dz_d;
  logic       load_q, load_d;
  logic       sll_q, sll_d;
  logic       srh_q, srh_d;
  logic       ready_q, ready_d;
  logic [5:0] alu_q, alu_d;

  logic       cnt_clr_s;
  logic       cnt_inc_s;
  logic       cnt_term_s;

  // The count is cleared in LOAD so the first ITER cycle sees zero.
  assign cnt_clr_s = (state_q == LOAD);
  assign cnt_inc_s = (state_q == ITER);

  div_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .term  (cnt_term_s)
  );

  // Next state and divide-by-zero flag.
  always_comb begin
    state_d = state_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          if (div_zero) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = LOAD;
            dz_d    = dz_q;
          end
        end else begin
          state_d = IDLE;
          dz_d    = dz_q;
        end
      end
      LOAD: begin
        state_d = SHIFT0;
        dz_d    = 1'b0;
      end
      SHIFT0: state_d = ITER;
      ITER: begin
        if (cnt_term_s) begin
          state_d = FIX;
        end else begin
          state_d = ITER;
        end
      end
      FIX: state_d = DONE;
      DONE: begin
        // A held run does not retrigger; the flag is dropped on the way out
        // so IDLE presents all-zero outputs.
        if (run) begin
          state_d = DONE;
          dz_d    = dz_q;
        end else begin
          state_d = IDLE;
          dz_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        dz_d    = 1'b0;
      end
    endcase
  end

  // Moore outputs decoded from the next state so the registered copies
  // line up with the state they belong to.
  always_comb begin
    load_d  = (state_d == LOAD);
    sll_d   = (state_d == SHIFT0) || (state_d == ITER);
    srh_d   = (state_d == FIX);
    ready_d = (state_d == DONE);
    alu_d   = alu_for_state(state_d);
  end

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dz_q    <= 1'b0;
      load_q  <= 1'b0;
      sll_q   <= 1'b0;
      srh_q   <= 1'b0;
      ready_q <= 1'b0;
      alu_q   <= ALU_NOP;
    end else begin
      state_q <= state_d;
      dz_q    <= dz_d;
      load_q  <= load_d;
      sll_q   <= sll_d;
      srh_q   <= srh_d;
      ready_q <= ready_d;
      alu_q   <= alu_d;
    end
  end

  assign load_ctrl = load_q;
  assign sll_ctrl  = sll_q;
  assign srh_ctrl  = srh_q;
  assign ready     = ready_q;
  assign alu_ctrl  = alu_q;
  assign dz        = dz_q;

  // Non-negative difference: keep it and shift in a 1.
  assign w_ctrl = (state_q == ITER) & ~msb;
  assign q_bit  = (state_q == ITER) & ~msb;

endmodule

// File: tb/tb_div_control.sv
// Bench for div_control: a WIDTH=4 and a WIDTH=32 instance share the clock.
// Inputs are driven and outputs sampled on the falling edge.
module tb_div_control;

  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_NOP  = 6'b000000;

  logic       clk;
  logic       reset[2];
  logic       run[2];
  logic       msb[2];
  logic       div_zero[2];
  logic       load_ctrl[2];
  logic [5:0] alu_ctrl[2];
  logic       w_ctrl[2];
  logic       sll_ctrl[2];
  logic       q_bit[2];
  logic       srh_ctrl[2];
  logic       ready[2];
  logic       dz[2];

  int n_tests = 0;
  int n_fail  = 0;
  int w_cnt;
  int first_rdy;

  div_control #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset[0]), .run(run[0]), .msb(msb[0]), .div_zero(div_zero[0]),
    .load_ctrl(load_ctrl[0]), .alu_ctrl(alu_ctrl[0]), .w_ctrl(w_ctrl[0]),
    .sll_ctrl(sll_ctrl[0]), .q_bit(q_bit[0]), .srh_ctrl(srh_ctrl[0]),
    .ready(ready[0]), .dz(dz[0])
  );

  div_control #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset[1]), .run(run[1]), .msb(msb[1]), .div_zero(div_zero[1]),
    .load_ctrl(load_ctrl[1]), .alu_ctrl(alu_ctrl[1]), .w_ctrl(w_ctrl[1]),
    .sll_ctrl(sll_ctrl[1]), .q_bit(q_bit[1]), .srh_ctrl(srh_ctrl[1]),
    .ready(ready[1]), .dz(dz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Output bundle: {alu[5:0], load, sll, w, q, srh, ready, dz}
  function automatic logic [12:0] pk(input logic [5:0] a, input logic ld, input logic sl,
                                     input logic w, input logic q, input logic sr,
                                     input logic rd, input logic z);
    return {a, ld, sl, w, q, sr, rd, z};
  endfunction

  function automatic logic [12:0] act(input int d);
    return pk(alu_ctrl[d], load_ctrl[d], sll_ctrl[d], w_ctrl[d], q_bit[d],
              srh_ctrl[d], ready[d], dz[d]);
  endfunction

  task automatic chk(input int d, input string nm, input int k, input logic [12:0] e);
    logic [12:0] a;
    a = act(d);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %b expected %b", nm, d, k, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // Reference timeline: cycle k counts falling edges after the start edge.
  // Normal op: 1 load, 1 initial shift, W iterations, 1 fix, then DONE from
  // cycle W+4 until done_end. Divide-by-zero: DONE from cycle 1.
  function automatic logic [12:0] exp_op(input int w, input int k, input bit zero,
                                         input bit m, input int done_end);
    int d_start;
    d_start = zero ? 1 : w + 4;
    if (k == 0) return 13'd0;
    if (k >= d_start) return (k <= done_end) ? pk(F_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, zero)
                                             : 13'd0;
    if (k == 1) return pk(F_NOP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (k == 2) return pk(F_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (k <= w + 2) return pk(F_SUBU, 1'b0, 1'b1, ~m, ~m, 1'b0, 1'b0, 1'b0);
    return pk(F_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  // One complete operation from IDLE back to IDLE. run is high for cycles
  // 0..run_len; msb outside ITER is random noise that must be ignored.
  task automatic do_op(input int d, input int w, input bit zero, input bit [63:0] mask,
                       input int run_len, input string nm);
    int d_start;
    int e_end;
    bit m;
    d_start   = zero ? 1 : w + 4;
    e_end     = (run_len + 1 > d_start) ? run_len + 1 : d_start;
    w_cnt     = 0;
    first_rdy = -1;
    for (int k = 0; k <= e_end + 1; k++) begin
      @(negedge clk);
      run[d]      = (k <= run_len);
      div_zero[d] = (k == 0) ? zero : 1'($urandom);
      m           = (k >= 3 && k <= w + 2) ? mask[k-3] : 1'($urandom);
      msb[d]      = m;
      #1;
      chk(d, nm, k, exp_op(w, k, zero, m, e_end));
      if (w_ctrl[d] === 1'b1) w_cnt++;
      if (ready[d] === 1'b1 && first_rdy < 0) first_rdy = k;
    end
    run[d] = 1'b0;
  endtask

  typedef struct {
    logic        run;
    logic        msb;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int d_start;
    bit zero;
    bit [63:0] mask;

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; run[d] = 1'b1; msb[d] = 1'b0; div_zero[d] = 1'b0;
    end

    // Reset held two cycles with run high: reset wins, outputs stay 0.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk(0, "reset_hold", c, 13'd0);
      chk(1, "reset_hold", c, 13'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin reset[d] = 1'b0; run[d] = 1'b0; end
    @(negedge clk);
    chk(0, "idle_after_reset", 0, 13'd0);
    chk(1, "idle_after_reset", 0, 13'd0);

    // WIDTH=4, 7/2: msb 1,1,0,0 in the four iterations.
    tbl[0] = '{1'b1, 1'b0, 13'd0};
    tbl[1] = '{1'b0, 1'b1, pk(F_NOP,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[2] = '{1'b0, 1'b1, pk(F_NOP,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[3] = '{1'b0, 1'b1, pk(F_SUBU, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[4] = '{1'b0, 1'b1, pk(F_SUBU, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[5] = '{1'b0, 1'b0, pk(F_SUBU, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[6] = '{1'b0, 1'b0, pk(F_SUBU, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[7] = '{1'b0, 1'b0, pk(F_NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[8] = '{1'b0, 1'b0, pk(F_NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[9] = '{1'b0, 1'b0, 13'd0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      run[0] = tbl[i].run;
      msb[0] = tbl[i].msb;
      div_zero[0] = 1'b0;
      #1;
      chk(0, "w4_table", i, tbl[i].exp);
    end

    // WIDTH=32, every iteration non-negative: 32 writes, ready after edge 35.
    do_op(1, 32, 1'b0, 64'd0, 0, "w32_all_write");
    chk_int("w32_write_count", w_cnt, 32);
    chk_int("w32_ready_edge", first_rdy - 1, 35);

    // Divide by zero: ready the cycle after the start edge, no strobes.
    do_op(1, 32, 1'b1, 64'd0, 0, "w32_div_zero");
    chk_int("dz_ready_edge", first_rdy - 1, 0);
    do_op(0, 4, 1'b1, 64'd0, 0, "w4_div_zero");

    // run held five cycles in DONE: no retrigger, IDLE one edge after release.
    do_op(1, 32, 1'b0, {$urandom, $urandom}, 36 + 4, "w32_run_held");
    do_op(0, 4, 1'b0, 64'hA, 8 + 4, "w4_run_held");

    // Reset during the 10th iteration (cycle 12), run kept high through reset.
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      run[1] = 1'b1;
      div_zero[1] = 1'b0;
      msb[1] = 1'($urandom);
      #1;
      chk(1, "pre_reset", k, exp_op(32, k, 1'b0, msb[1], 1000));
    end
    reset[1] = 1'b1;
    @(negedge clk);
    chk(1, "mid_reset", 13, 13'd0);
    reset[1] = 1'b0;
    run[1] = 1'b0;
    @(negedge clk);
    chk(1, "post_reset_idle", 0, 13'd0);
    do_op(1, 32, 1'b0, {$urandom, $urandom}, 0, "w32_after_reset");
    chk_int("after_reset_ready_edge", first_rdy - 1, 35);

    // Randomized operations on both widths.
    for (int i = 0; i < 24; i++) begin
      int d;
      int w;
      d       = i % 2;
      w       = (d == 0) ? 4 : 32;
      zero    = ($urandom_range(0, 4) == 0);
      mask    = {$urandom, $urandom};
      d_start = zero ? 1 : w + 4;
      do_op(d, w, zero, mask, $urandom_range(0, d_start + 6), "random_op");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_control.md
Name: div_control

Overview:
- Sequencing FSM for the multi-cycle restoring-division datapath (divisor register, ALU subtractor, 2*WIDTH remainder/quotient register).
- Companion to the shift-add multiplier controller; drives the same style of ALU funct code and write/shift strobes.
- One quotient bit per cycle: subtract, conditionally write, shift left with quotient bit.
- Final cycle corrects the remainder half. Handles divide-by-zero without touching the datapath.

Parameters:
- WIDTH, 32, operand width; equals the number of quotient iterations (WIDTH >= 2).
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- run  input  1  start request, level-sampled in IDLE
- msb  input  1  sign bit of ALU result (rem_hi - divisor); 1 means negative, so no write
- div_zero  input  1  datapath flag: divisor operand == 0, valid while in IDLE
- load_ctrl  output  1  load {WIDTH'b0, dividend} into remainder register and latch divisor
- alu_ctrl  output  6  ALU funct: SUBU 6'b100011 during ITER, NOP 6'b000000 otherwise
- w_ctrl  output  1  write ALU difference into rem_hi (this edge, before shift)
- sll_ctrl  output  1  shift remainder register left 1, inserting q_bit at LSB
- q_bit  output  1  quotient bit inserted on shift
- srh_ctrl  output  1  shift rem_hi right 1 (final correction)
- ready  output  1  result valid
- dz  output  1  divide-by-zero flag, valid with ready

Behaviour:
- All outputs Moore-decoded from state, except w_ctrl and q_bit (combinational on msb in ITER).
- Reset: state=IDLE, counter=0, dz register=0. All outputs 0, including ready.
- IDLE: outputs 0.
  - run=1 and div_zero=0 -> LOAD.
  - run=1 and div_zero=1 -> DONE with dz<=1; no load/write/shift strobes are ever asserted.
  - run=0 -> stay in IDLE.
- LOAD (1 cycle): load_ctrl=1, counter<=0, dz<=0 -> SHIFT0.
- SHIFT0 (1 cycle): sll_ctrl=1, q_bit=0 -> ITER.
- ITER (WIDTH cycles):
  - alu_ctrl=SUBU, sll_ctrl=1, w_ctrl=~msb, q_bit=~msb.
  - Datapath applies write then shift on the same edge.
  - counter increments; when counter==WIDTH-1 at the edge -> FIX.
- FIX (1 cycle): srh_ctrl=1 -> DONE.
- DONE: ready=1, dz=registered flag.
  - Stays in DONE while run=1 (no retrigger on a held run). run=0 -> IDLE.
- Latency: edge sampling run=1 in IDLE is edge 0; ready first high after edge WIDTH+3 (WIDTH=32: edge 35).
  - Divide-by-zero path: ready high after edge 0 (next cycle).
- run deasserted mid-operation: ignored; the operation completes, DONE is entered, then IDLE on the next edge.
- reset mid-operation: next edge forces IDLE with all outputs 0, counter=0, dz=0. The partial datapath result is abandoned.
- reset and run both high: reset wins.
- msb is sampled only in ITER; ignored in every other state.
- At most one of load_ctrl, srh_ctrl, sll_ctrl is high in any cycle.

Decomposition:
- div_ctrl_pkg holds:
  - state enum: IDLE, LOAD, SHIFT0, ITER, FIX, DONE.
  - constants ALU_SUBU=6'b100011, ALU_NOP=6'b000000, shared with the multiplier controller's funct set.
- One sub-module, div_iter_counter:
  - inputs: clr, inc
  - output: terminal flag at WIDTH-1
  - synchronous reset.
- FSM and output decode stay in div_control.

Test Plan:
- Reset: hold reset 2 cycles with run=1 -> all outputs 0, state IDLE, ready=0 throughout.
- WIDTH=4, 7/2 (bench drives msb=1,1,0,0 in ITER) -> load_ctrl at cycle 1, sll_ctrl cycles 2-6, q_bit/w_ctrl = 0,0,1,1 in cycles 3-6, alu_ctrl=6'b100011 only in cycles 3-6, srh_ctrl cycle 7, ready from cycle 8.
- WIDTH=32, msb=0 every ITER cycle -> exactly 32 cycles with w_ctrl=1, ready first high 35 edges after the start edge, dz=0.
- div_zero=1 at start -> DONE next cycle with ready=1, dz=1; load_ctrl, w_ctrl, sll_ctrl, srh_ctrl never asserted.
- run held high through DONE for 5 cycles -> remains DONE with ready=1, no second LOAD; run=0 -> IDLE next edge.
- reset asserted during ITER cycle 10 -> IDLE next edge with outputs 0; a fresh run then gives full-length latency (ready 35 edges after the start edge, WIDTH=32).
